ps2_scancode_decoder: RTL and testbench
=======================================

// Module: ps2_scancode_decoder
// PURPOSE
//  Consumes the byte stream from the PS/2 keyboard receiver (one byte per byte_valid pulse) and
//  assembles PS/2 set-2 prefixes (E0, F0, E1) into single key events.
//  Each event carries make/break, extended flag, scan code and ASCII. The block also tracks
//  shift/caps state and drives one active-low 7-seg digit for hex keys 0-9, a-f.
//  Sits between the keyboard receiver and the display/LED logic.
// PARAMETERS
//  SUPPRESS_REPEAT  1  1: drop typematic repeat makes of the currently held key; 0: pass them through
// PORTS
//  clk         input   1  system clock
//  clr         input   1  asynchronous active-high reset
//  byte_data   input   8  received scan byte; valid only while byte_valid=1
//  byte_valid  input   1  1-cycle strobe; may assert on consecutive cycles
//  key_valid   output  1  1-cycle event strobe
//  key_code    output  8  scan code of the event (8'hE1 for Pause)
//  key_ext     output  1  event had an E0 prefix
//  key_break   output  1  1 = release, 0 = press
//  ascii       output  8  ASCII of the press; 8'h00 on a release or for an unmapped/extended key
//  shift_on    output  1  left (12) or right (59) shift currently held
//  caps_on     output  1  caps-lock toggle state
//  err         output  1  1-cycle strobe on an illegal prefix sequence
//  seg         output  7  active-low segments {g..a} of the last hex key pressed
// BEHAVIOUR
//  - Reset (async, clr=1): state=IDLE, skip count 0, all outputs 0 except seg=7'b1111111.
//    shift/caps and held-key register are cleared. clr wins over a coincident byte_valid.
//  - Throughput is 1 byte/clk. Latency: key_valid/err assert in the cycle after the byte_valid
//    of the terminating byte. key_code/ext/break/ascii are registered with key_valid and hold
//    until the next event.
//  - FSM states: IDLE, E0, F0, E0F0, SKIP.
//  - IDLE:
//    . E0 -> E0; F0 -> F0; E1 -> SKIP with skip count 7.
//    . AA, FA, EE, FE, FC, 00, FF -> ignored; no event.
//    . any other byte -> make event, ext=0.
//  - E0: F0 -> E0F0; 12 or 59 -> fake-shift, discarded, back to IDLE; other byte -> make, ext=1.
//  - F0: byte -> break, ext=0. E0F0: byte -> break, ext=1.
//    In F0/E0F0, a byte of E0, F0 or E1 raises err, gives no event, and returns to IDLE.
//  - E0 seen in state E0 raises err and returns to IDLE.
//  - SKIP: each byte decrements the count. At the 7th byte, emit one make event
//    (code E1, ext=0, ascii 0) and go to IDLE. The break codes inside the sequence never emit.
//  - Repeat suppression (SUPPRESS_REPEAT=1): a held register {valid, ext, code} is set on a make.
//    . A make matching the held register emits nothing.
//    . A break matching it clears it. A non-matching break emits but leaves it unchanged.
//  - Shift: shift_on = lshift_held | rshift_held, updated on 12/59 make/break with ext=0.
//    caps_on toggles on each emitted make of 58, ext=0.
//  - ASCII on a make with ext=0:
//    . Letters give 61-7A; uppercase 41-5A when shift_on^caps_on.
//    . Digits 45,16,1E,26,25,2E,36,3D,3E,46 give '0'-'9'; with shift_on they give ")!@#$%^&*(".
//    . 29 gives 20, 5A gives 0D, 66 gives 08, 0D gives 09.
//    . Keypad 70,69,72,7A,6B,73,74,6C,75,7D give '0'-'9'. All else gives 00.
//    . ASCII uses the shift/caps state from before the current byte.
//  - seg updates only on an emitted make (ext=0) of a keypad digit or of letters a-f
//    (1C,32,21,23,24,2B).
//    . 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000
//    . 8=0000000 9=0010000 a=0001000 b=0000011 c=0100111 d=0100001 e=0000110 f=0001110
//    . Otherwise seg holds its value.
//  - Reset mid-sequence (e.g. after E0) discards the partial prefix; the next byte decodes from IDLE.
// TESTING
//  1) bytes 1C -> one key_valid, code=1C ext=0 break=0 ascii=61 seg=0001000; F0,1C -> break=1 ascii=00.
//  2) 12, 1C, F0 1C, F0 12, 1C -> ascii 41 then 61; shift_on 1 then 0; 58 -> caps_on=1; 1C -> ascii 41.
//  3) E0 75 -> ext=1 code=75 ascii=00, seg unchanged; E0 F0 75 -> break=1 ext=1.
//  4) E1 14 77 E1 F0 14 F0 77 on back-to-back clocks -> exactly one event, code=E1, break=0.
//  5) SUPPRESS_REPEAT=1: 69 69 69 F0 69 69 -> events: make 69, break 69, make 69; seg=1111001.
//  6) F0 F0 -> err pulse, no event; E0 then clr=1 then 1C -> make 1C ext=0. AA -> no event.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan code decoder.
// Folds the E0/F0/E1 prefixes from the receiver's byte stream into single key
// events. It also tracks shift and caps lock, and drives one active-low
// 7-segment digit from the last hex key pressed.
module ps2_scancode_decoder #(
  parameter bit SUPPRESS_REPEAT = 1'b1
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic [7:0] ascii,
  output logic       shift_on,
  output logic       caps_on,
  output logic       err,
  output logic [6:0] seg
);

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BREAK = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [2:0] {ST_IDLE, ST_E0, ST_F0, ST_E0F0, ST_SKIP} state_t;

  state_t     state, state_n;
  logic [2:0] skip_cnt, skip_n;

  // Decoded event before repeat suppression.
  logic       ev_valid, ev_break, ev_ext, ev_pause, err_n;
  logic [7:0] ev_code;

  // Held-key register used for typematic repeat suppression.
  logic       held_valid, held_ext;
  logic [7:0] held_code;
  logic       held_match, emit, is_make;

  logic       lshift_held, rshift_held;

  // Keyboard housekeeping bytes (BAT result, ACK, echo, resend, errors).
  function automatic logic is_ignored(input logic [7:0] b);
    case (b)
      8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: is_ignored = 1'b1;
      default:                                         is_ignored = 1'b0;
    endcase
  endfunction

  // ASCII for a non-extended make. upper selects capitals for letters only.
  // shift selects the symbol row for the top-row digits.
  function automatic logic [7:0] ascii_of(input logic [7:0] code,
                                          input logic       upper,
                                          input logic       shift);
    logic [7:0] a;
    a = 8'h00;
    case (code)
      8'h1C: a = "a";  8'h32: a = "b";  8'h21: a = "c";  8'h23: a = "d";
      8'h24: a = "e";  8'h2B: a = "f";  8'h34: a = "g";  8'h33: a = "h";
      8'h43: a = "i";  8'h3B: a = "j";  8'h42: a = "k";  8'h4B: a = "l";
      8'h3A: a = "m";  8'h31: a = "n";  8'h44: a = "o";  8'h4D: a = "p";
      8'h15: a = "q";  8'h2D: a = "r";  8'h1B: a = "s";  8'h2C: a = "t";
      8'h3C: a = "u";  8'h2A: a = "v";  8'h1D: a = "w";  8'h22: a = "x";
      8'h35: a = "y";  8'h1A: a = "z";
      8'h45: a = shift ? ")" : "0";
      8'h16: a = shift ? "!" : "1";
      8'h1E: a = shift ? "@" : "2";
      8'h26: a = shift ? "#" : "3";
      8'h25: a = shift ? "$" : "4";
      8'h2E: a = shift ? "%" : "5";
      8'h36: a = shift ? "^" : "6";
      8'h3D: a = shift ? "&" : "7";
      8'h3E: a = shift ? "*" : "8";
      8'h46: a = shift ? "(" : "9";
      8'h29: a = 8'h20;
      8'h5A: a = 8'h0D;
      8'h66: a = 8'h08;
      8'h0D: a = 8'h09;
      8'h70: a = "0";  8'h69: a = "1";  8'h72: a = "2";  8'h7A: a = "3";
      8'h6B: a = "4";  8'h73: a = "5";  8'h74: a = "6";  8'h6C: a = "7";
      8'h75: a = "8";  8'h7D: a = "9";
      default: a = 8'h00;
    endcase
    if (upper && a >= "a" && a <= "z") a = a - 8'h20;
    return a;
  endfunction

  // Hex value of keypad digits and letters a-f; bit 4 flags a hit.
  function automatic logic [4:0] hex_of(input logic [7:0] code);
    case (code)
      8'h70: hex_of = 5'h10;  8'h69: hex_of = 5'h11;
      8'h72: hex_of = 5'h12;  8'h7A: hex_of = 5'h13;
      8'h6B: hex_of = 5'h14;  8'h73: hex_of = 5'h15;
      8'h74: hex_of = 5'h16;  8'h6C: hex_of = 5'h17;
      8'h75: hex_of = 5'h18;  8'h7D: hex_of = 5'h19;
      8'h1C: hex_of = 5'h1A;  8'h32: hex_of = 5'h1B;
      8'h21: hex_of = 5'h1C;  8'h23: hex_of = 5'h1D;
      8'h24: hex_of = 5'h1E;  8'h2B: hex_of = 5'h1F;
      default: hex_of = 5'h00;
    endcase
  endfunction

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: seg_of = 7'b1000000;  4'h1: seg_of = 7'b1111001;
      4'h2: seg_of = 7'b0100100;  4'h3: seg_of = 7'b0110000;
      4'h4: seg_of = 7'b0011001;  4'h5: seg_of = 7'b0010010;
      4'h6: seg_of = 7'b0000010;  4'h7: seg_of = 7'b1111000;
      4'h8: seg_of = 7'b0000000;  4'h9: seg_of = 7'b0010000;
      4'hA: seg_of = 7'b0001000;  4'hB: seg_of = 7'b0000011;
      4'hC: seg_of = 7'b0100111;  4'hD: seg_of = 7'b0100001;
      4'hE: seg_of = 7'b0000110;  default: seg_of = 7'b0001110;
    endcase
  endfunction

  // Prefix FSM state register and Pause skip counter.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= ST_IDLE;
      skip_cnt <= 3'd0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values, whatever order the blocks are evaluated in.
      state    <= state_n;
      skip_cnt <= skip_n;
    end
  end

  // Next-state logic and decoding of the raw key event for the current byte.
  always_comb begin
    // NOTE: every output of this block gets a default first. No path can then
    // leave a signal unassigned, so no latch is inferred.
    state_n  = state;
    skip_n   = skip_cnt;
    ev_valid = 1'b0;
    ev_break = 1'b0;
    ev_ext   = 1'b0;
    ev_pause = 1'b0;
    ev_code  = byte_data;
    err_n    = 1'b0;
    if (byte_valid) begin
      case (state)
        ST_IDLE: begin
          if (byte_data == PFX_EXT)        state_n = ST_E0;
          else if (byte_data == PFX_BREAK) state_n = ST_F0;
          else if (byte_data == PFX_PAUSE) begin
            state_n = ST_SKIP;
            skip_n  = 3'd7;
          end else if (!is_ignored(byte_data)) ev_valid = 1'b1;
        end
        ST_E0: begin
          state_n = ST_IDLE;
          if (byte_data == PFX_BREAK)    state_n = ST_E0F0;
          else if (byte_data == PFX_EXT) err_n = 1'b1;
          else if (byte_data != SC_LSHIFT && byte_data != SC_RSHIFT) begin
            // E0 12 / E0 59 are the fake shifts around extended keys.
            ev_valid = 1'b1;
            ev_ext   = 1'b1;
          end
        end
        ST_F0, ST_E0F0: begin
          state_n = ST_IDLE;
          if (byte_data == PFX_EXT || byte_data == PFX_BREAK ||
              byte_data == PFX_PAUSE) begin
            err_n = 1'b1;
          end else begin
            ev_valid = 1'b1;
            ev_break = 1'b1;
            ev_ext   = (state == ST_E0F0);
          end
        end
        ST_SKIP: begin
          skip_n = skip_cnt - 3'd1;
          if (skip_cnt <= 3'd1) begin
            state_n  = ST_IDLE;
            ev_valid = 1'b1;
            ev_pause = 1'b1;
            ev_code  = PFX_PAUSE;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Repeat suppression: drop makes of the key currently held. Pause has no
  // break code and could never be released, so it bypasses the held register.
  always_comb begin
    held_match = held_valid && (held_ext == ev_ext) && (held_code == ev_code);
    is_make    = ev_valid && !ev_break;
    emit       = ev_valid &&
                 !(SUPPRESS_REPEAT && is_make && !ev_pause && held_match);
  end

  // Event outputs, held key, shift/caps state and the hex display.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      key_valid   <= 1'b0;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_break   <= 1'b0;
      ascii       <= 8'h00;
      err         <= 1'b0;
      seg         <= SEG_BLANK;
      lshift_held <= 1'b0;
      rshift_held <= 1'b0;
      caps_on     <= 1'b0;
      held_valid  <= 1'b0;
      held_ext    <= 1'b0;
      held_code   <= 8'h00;
    end else begin
      key_valid <= emit;
      err       <= err_n;
      if (emit) begin
        key_code  <= ev_code;
        key_ext   <= ev_ext;
        key_break <= ev_break;
        ascii     <= (is_make && !ev_ext)
                     ? ascii_of(ev_code, shift_on ^ caps_on, shift_on)
                     : 8'h00;
        if (is_make && !ev_ext && hex_of(ev_code)[4])
          seg <= seg_of(hex_of(ev_code)[3:0]);
        if (is_make && !ev_ext && ev_code == SC_CAPS)
          caps_on <= ~caps_on;
      end
      if (ev_valid && !ev_ext && !ev_pause) begin
        if (ev_code == SC_LSHIFT) lshift_held <= !ev_break;
        if (ev_code == SC_RSHIFT) rshift_held <= !ev_break;
      end
      if (SUPPRESS_REPEAT && ev_valid && !ev_pause) begin
        if (!ev_break && !held_match) begin
          held_valid <= 1'b1;
          held_ext   <= ev_ext;
          held_code  <= ev_code;
        end else if (ev_break && held_match) begin
          held_valid <= 1'b0;
        end
      end
    end
  end

  assign shift_on = lshift_held | rshift_held;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder. Each expected event is queued
// as its bytes are driven and checked when key_valid appears.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic [7:0] ascii;
  logic       shift_on;
  logic       caps_on;
  logic       err;
  logic [6:0] seg;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] asc;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  err_seen = 0;
  int  err_exp = 0;

  ps2_scancode_decoder #(.SUPPRESS_REPEAT(1'b1)) dut (
    .clk(clk), .clr(clr), .byte_data(byte_data), .byte_valid(byte_valid),
    .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
    .key_break(key_break), .ascii(ascii), .shift_on(shift_on),
    .caps_on(caps_on), .err(err), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] code, input logic ext,
                      input logic brk, input logic [7:0] asc);
    ev_t e;
    e.code = code; e.ext = ext; e.brk = brk; e.asc = asc;
    exp_q.push_back(e);
  endtask

  // Drive one byte for exactly one clock; consecutive calls are back-to-back.
  task automatic put(input logic [7:0] b);
    byte_data  = b;
    byte_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    clr = 1'b1;
    byte_data = 8'h00;
    byte_valid = 1'b0;

    // Output monitor: compare each event against the queue head, count err.
    fork
      forever begin
        @(negedge clk);
        if (err) err_seen++;
        if (key_valid) begin
          if (exp_q.size() == 0) begin
            check("spurious_event", {24'h0, key_code}, 32'hFFFF_FFFF);
          end else begin
            ev_t e;
            e = exp_q.pop_front();
            check("key_code", key_code, e.code);
            check("key_ext", key_ext, e.ext);
            check("key_break", key_break, e.brk);
            check("ascii", ascii, e.asc);
          end
        end
      end
    join_none

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_code", key_code, 0);
    check("rst_ascii", ascii, 0);
    check("rst_seg", seg, 7'b1111111);
    check("rst_shift", shift_on, 0);
    check("rst_caps", caps_on, 0);
    check("rst_err", err, 0);
    clr = 1'b0;
    @(negedge clk);

    // 1) plain make and break of 'a'
    push(8'h1C, 0, 0, 8'h61); put(8'h1C); idle(1);
    check("t1_seg_a", seg, 7'b0001000);
    push(8'h1C, 0, 1, 8'h00); put(8'hF0); put(8'h1C); idle(1);

    // 2) shift and caps lock
    push(8'h12, 0, 0, 8'h00); put(8'h12);
    check("t2_shift_on", shift_on, 1);
    push(8'h1C, 0, 0, 8'h41); put(8'h1C);
    push(8'h1C, 0, 1, 8'h00); put(8'hF0); put(8'h1C);
    push(8'h12, 0, 1, 8'h00); put(8'hF0); put(8'h12);
    check("t2_shift_off", shift_on, 0);
    push(8'h1C, 0, 0, 8'h61); put(8'h1C);
    push(8'h58, 0, 0, 8'h00); put(8'h58);
    check("t2_caps_on", caps_on, 1);
    push(8'h1C, 0, 0, 8'h41); put(8'h1C);
    push(8'h1C, 0, 1, 8'h00); put(8'hF0); put(8'h1C);
    push(8'h58, 0, 1, 8'h00); put(8'hF0); put(8'h58); idle(1);
    check("t2_caps_hold", caps_on, 1);

    // 3) extended keypad-8 code leaves seg alone
    push(8'h75, 1, 0, 8'h00); put(8'hE0); put(8'h75); idle(1);
    check("t3_seg_unchanged", seg, 7'b0001000);
    push(8'h75, 1, 1, 8'h00); put(8'hE0); put(8'hF0); put(8'h75); idle(1);

    // 4) Pause sequence back-to-back gives one event
    push(8'hE1, 0, 0, 8'h00);
    put(8'hE1); put(8'h14); put(8'h77); put(8'hE1);
    put(8'hF0); put(8'h14); put(8'hF0); put(8'h77); idle(3);
    check("t4_pending", exp_q.size(), 0);

    // 5) typematic repeat suppression on keypad 1 (caps is still on)
    push(8'h69, 0, 0, 8'h31); put(8'h69); put(8'h69); put(8'h69);
    push(8'h69, 0, 1, 8'h00); put(8'hF0); put(8'h69);
    push(8'h69, 0, 0, 8'h31); put(8'h69); idle(1);
    check("t5_seg_1", seg, 7'b1111001);
    push(8'h69, 0, 1, 8'h00); put(8'hF0); put(8'h69); idle(2);
    check("t5_pending", exp_q.size(), 0);

    // 6) illegal prefixes, then recovery into IDLE
    put(8'hF0); put(8'hF0);
    put(8'hE0); put(8'hE0);
    put(8'hF0); put(8'hE1);
    push(8'h32, 0, 0, 8'h42); put(8'h32); idle(1);
    check("t6_seg_b", seg, 7'b0000011);
    push(8'h32, 0, 1, 8'h00); put(8'hF0); put(8'h32); idle(2);
    err_exp = 3;
    check("t6_err_count", err_seen, err_exp);

    // fake shift and housekeeping bytes: no events, shift stays off
    put(8'hE0); put(8'h12);
    put(8'hAA); put(8'hFA); put(8'h00); put(8'hFF); idle(2);
    check("t6_fake_shift", shift_on, 0);
    check("t6_no_event", exp_q.size(), 0);

    // reset after E0 with a coincident byte_valid; the prefix is discarded
    put(8'hE0);
    clr = 1'b1; byte_data = 8'h1C; byte_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("clr_key_valid", key_valid, 0);
    check("clr_key_code", key_code, 0);
    check("clr_caps", caps_on, 0);
    check("clr_seg", seg, 7'b1111111);
    byte_valid = 1'b0; clr = 1'b0;
    @(negedge clk);
    push(8'h1C, 0, 0, 8'h61); put(8'h1C); idle(1);
    check("clr_seg_a", seg, 7'b0001000);

    // shifted digit, plain digit, keypad 9, ext mismatch, space
    push(8'h12, 0, 0, 8'h00); put(8'h12);
    push(8'h16, 0, 0, 8'h21); put(8'h16);
    push(8'h16, 0, 1, 8'h00); put(8'hF0); put(8'h16);
    push(8'h12, 0, 1, 8'h00); put(8'hF0); put(8'h12);
    push(8'h45, 0, 0, 8'h30); put(8'h45);
    push(8'h7D, 0, 0, 8'h39); put(8'h7D); idle(1);
    check("seg_9", seg, 7'b0010000);
    push(8'h7D, 1, 0, 8'h00); put(8'hE0); put(8'h7D);
    push(8'h29, 0, 0, 8'h20); put(8'h29); idle(4);

    check("final_pending", exp_q.size(), 0);
    check("final_err_count", err_seen, err_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
